// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared constants for the MINI-RISC pipeline sequencer: EX opcodes it reacts to and FSM states.
package pipeline_hazard_sequencer_pkg;

    localparam logic [4:0] MUL  = 5'h0C;
    localparam logic [4:0] DIV  = 5'h0D;
    localparam logic [4:0] HALT = 5'h1F;

    typedef enum logic [1:0] {
        SEQ_RUN     = 2'd0,
        SEQ_MD_WAIT = 2'd1,
        SEQ_HALTED  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pipeline_hazard_sequencer_md_latency_counter.sv
// Down-counter that tracks the remaining EX occupancy of a multi-cycle MUL/DIV.
module md_latency_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// MINI-RISC pipeline sequencer: the single source of stall, flush and bubble control
// for load-use hazards, MUL/DIV occupancy of EX, taken redirects and HALT.
module pipeline_hazard_sequencer
    import pipeline_hazard_sequencer_pkg::*;
#(
    parameter int REG_AW  = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_valid,
    input  logic [4:0]        ex_opcode,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_redirect,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_bubble,
    output logic              ex_mem_bubble,
    output logic              md_busy,
    output logic              halted,
    output logic [15:0]       stall_cycles
);

    // The detect cycle is itself a stall, so the counter starts at LAT-2.
    localparam bit               MUL_STALLS = (MUL_LAT > 1);
    localparam bit               DIV_STALLS = (DIV_LAT > 1);
    localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_STALLS ? MUL_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_STALLS ? DIV_LAT - 2 : 0);

    seq_state_t       state;
    seq_state_t       state_next;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_zero;

    logic halt_hit;
    logic md_hit;
    logic load_use;

    assign halt_hit = ex_valid && (ex_opcode == HALT);
    assign md_hit   = ex_valid && (((ex_opcode == MUL) && MUL_STALLS) ||
                                   ((ex_opcode == DIV) && DIV_STALLS));
    assign load_use = ex_valid && ex_mem_read &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    md_latency_counter #(
        .CNT_W(CNT_W)
    ) u_md_latency_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEQ_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        cnt_load_value = '0;
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_en       = 1'b1;
        id_ex_bubble   = 1'b0;
        ex_mem_bubble  = 1'b0;
        md_busy        = 1'b0;
        halted         = 1'b0;

        if (rst) begin
            state_next    = SEQ_RUN;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (state == SEQ_HALTED) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            halted   = 1'b1;
        end else if (state == SEQ_MD_WAIT && !cnt_zero) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            md_busy       = 1'b1;
            cnt_dec       = 1'b1;
        end else begin
            // RUN, or the MD release cycle where the finishing MUL/DIV must not re-trigger.
            state_next = SEQ_RUN;
            if (halt_hit) begin
                state_next   = SEQ_HALTED;
                pc_en        = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (md_hit && state == SEQ_RUN) begin
                state_next     = SEQ_MD_WAIT;
                cnt_load       = 1'b1;
                cnt_load_value = (ex_opcode == DIV) ? DIV_LOAD : MUL_LOAD;
                pc_en          = 1'b0;
                if_id_en       = 1'b0;
                id_ex_en       = 1'b0;
                ex_mem_bubble  = 1'b1;
                md_busy        = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!pc_en && !halted && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Self-checking bench: directed scenarios then random traffic, two DUT instances with
// different MUL/DIV latencies compared against an occupancy-age reference model.
module tb_pipeline_hazard_sequencer;
    import pipeline_hazard_sequencer_pkg::*;

    localparam logic [4:0] NOP  = 5'h00;
    localparam logic [4:0] LOAD = 5'h01;

    typedef struct packed {
        logic        pc_en;
        logic        if_id_en;
        logic        if_id_flush;
        logic        id_ex_en;
        logic        id_ex_bubble;
        logic        ex_mem_bubble;
        logic        md_busy;
        logic        halted;
        logic [15:0] stall_cycles;
    } exp_t;

    typedef struct packed {
        logic halted;
        int   md_age;
        int   md_lat;
        int   stall_count;
    } model_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_valid, ex_mem_read, ex_redirect;
    logic [4:0] ex_opcode;

    logic a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_en, a_id_ex_bubble, a_ex_mem_bubble, a_md_busy, a_halted;
    logic b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_en, b_id_ex_bubble, b_ex_mem_bubble, b_md_busy, b_halted;
    logic [15:0] a_stall_cycles, b_stall_cycles;

    int     n_asserts = 0;
    int     n_fail    = 0;
    model_t ma = '0;
    model_t mb = '0;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .pc_en(a_pc_en), .if_id_en(a_if_id_en),
        .if_id_flush(a_if_id_flush), .id_ex_en(a_id_ex_en), .id_ex_bubble(a_id_ex_bubble),
        .ex_mem_bubble(a_ex_mem_bubble), .md_busy(a_md_busy), .halted(a_halted),
        .stall_cycles(a_stall_cycles)
    );

    pipeline_hazard_sequencer #(.MUL_LAT(2), .DIV_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .pc_en(b_pc_en), .if_id_en(b_if_id_en),
        .if_id_flush(b_if_id_flush), .id_ex_en(b_id_ex_en), .id_ex_bubble(b_id_ex_bubble),
        .ex_mem_bubble(b_ex_mem_bubble), .md_busy(b_md_busy), .halted(b_halted),
        .stall_cycles(b_stall_cycles)
    );

    // Reference: a MUL/DIV of latency LAT is tracked by how many cycles it has sat in EX.
    function automatic void model_eval(input model_t m, input int mul_lat, input int div_lat,
                                       output exp_t e, output model_t n);
        int lat;
        bit release_cyc;
        bit lu;
        n = m;
        e.pc_en = 1'b1; e.if_id_en = 1'b1; e.if_id_flush = 1'b0; e.id_ex_en = 1'b1;
        e.id_ex_bubble = 1'b0; e.ex_mem_bubble = 1'b0; e.md_busy = 1'b0; e.halted = 1'b0;
        e.stall_cycles = m.stall_count[15:0];
        if (rst) begin
            e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_ex_en = 1'b0;
            e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1; e.ex_mem_bubble = 1'b1;
            n = '0;
            return;
        end
        if (m.halted) begin
            e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_ex_en = 1'b0; e.halted = 1'b1;
            return;
        end
        if (m.md_age > 0 && m.md_age < m.md_lat) begin
            e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_ex_en = 1'b0;
            e.ex_mem_bubble = 1'b1; e.md_busy = 1'b1;
            n.md_age = m.md_age + 1;
        end else begin
            release_cyc = (m.md_age > 0);
            n.md_age = 0;
            lat = (ex_opcode == DIV) ? div_lat : (ex_opcode == MUL) ? mul_lat : 0;
            lu = ex_valid && ex_mem_read &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            if (ex_valid && ex_opcode == HALT) begin
                e.pc_en = 1'b0; e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1;
                n.halted = 1'b1;
            end else if (!release_cyc && ex_valid && lat > 1) begin
                e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_ex_en = 1'b0;
                e.ex_mem_bubble = 1'b1; e.md_busy = 1'b1;
                n.md_age = 2;
                n.md_lat = lat;
            end else if (ex_redirect) begin
                e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1;
            end else if (lu) begin
                e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_ex_bubble = 1'b1;
            end
        end
        if (!e.pc_en && !e.halted && m.stall_count < 65535)
            n.stall_count = m.stall_count + 1;
    endfunction

    task automatic check_sig(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string who, input exp_t obs, input exp_t e);
        check_sig({who, ".pc_en"},         16'(obs.pc_en),         16'(e.pc_en));
        check_sig({who, ".if_id_en"},      16'(obs.if_id_en),      16'(e.if_id_en));
        check_sig({who, ".if_id_flush"},   16'(obs.if_id_flush),   16'(e.if_id_flush));
        check_sig({who, ".id_ex_en"},      16'(obs.id_ex_en),      16'(e.id_ex_en));
        check_sig({who, ".id_ex_bubble"},  16'(obs.id_ex_bubble),  16'(e.id_ex_bubble));
        check_sig({who, ".ex_mem_bubble"}, 16'(obs.ex_mem_bubble), 16'(e.ex_mem_bubble));
        check_sig({who, ".md_busy"},       16'(obs.md_busy),       16'(e.md_busy));
        check_sig({who, ".halted"},        16'(obs.halted),        16'(e.halted));
        check_sig({who, ".stall_cycles"},  obs.stall_cycles,       e.stall_cycles);
    endtask

    // Drives one cycle of inputs, checks both DUTs mid-cycle, then advances the model at the edge.
    task automatic apply_stimulus(input logic r, input logic v, input logic [4:0] op,
                                  input logic mr, input logic [2:0] rd, input logic redir,
                                  input logic [2:0] rs1, input logic u1,
                                  input logic [2:0] rs2, input logic u2);
        exp_t   ea, eb, oa, ob;
        model_t na, nb;
        rst = r; ex_valid = v; ex_opcode = op; ex_mem_read = mr; ex_rd = rd;
        ex_redirect = redir; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        model_eval(ma, 4, 8, ea, na);
        model_eval(mb, 2, 1, eb, nb);
        #2;
        oa = {a_pc_en, a_if_id_en, a_if_id_flush, a_id_ex_en, a_id_ex_bubble,
              a_ex_mem_bubble, a_md_busy, a_halted, a_stall_cycles};
        ob = {b_pc_en, b_if_id_en, b_if_id_flush, b_id_ex_en, b_id_ex_bubble,
              b_ex_mem_bubble, b_md_busy, b_halted, b_stall_cycles};
        check_output("A", oa, ea);
        check_output("B", ob, eb);
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
    endtask

    initial begin
        logic [4:0] op;
        int         k;
        rst = 1'b1; ex_valid = 1'b0; ex_opcode = NOP; ex_mem_read = 1'b0; ex_rd = 3'd0;
        ex_redirect = 1'b0; id_rs1 = 3'd0; id_rs2 = 3'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed: reset and load-use");
        apply_stimulus(1, 0, NOP,  0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, NOP,  0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, NOP,  0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, LOAD, 1, 2, 0, 2, 1, 5, 1);
        apply_stimulus(0, 0, NOP,  0, 0, 0, 2, 1, 5, 1);
        apply_stimulus(0, 1, LOAD, 1, 2, 0, 3, 1, 2, 0);
        apply_stimulus(0, 0, NOP,  0, 0, 0, 0, 0, 0, 0);

        $display("[TB] directed: MUL and DIV occupancy");
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, MUL, 0, 4, 0, 1, 1, 3, 1);
        apply_stimulus(0, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) apply_stimulus(0, 1, DIV, 0, 5, 0, 1, 1, 3, 1);
        apply_stimulus(0, 0, NOP, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] directed: redirect with load-use");
        apply_stimulus(0, 1, LOAD, 1, 6, 1, 6, 1, 0, 0);
        apply_stimulus(0, 0, NOP,  0, 0, 0, 0, 0, 0, 0);

        $display("[TB] directed: reset during DIV stall");
        apply_stimulus(0, 1, DIV, 0, 5, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, DIV, 0, 5, 0, 0, 0, 0, 0);
        apply_stimulus(1, 1, DIV, 0, 5, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, NOP, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] directed: HALT");
        apply_stimulus(0, 1, HALT, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, LOAD, 1, 1, 1, 1, 1, 1, 1);
        apply_stimulus(1, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, NOP, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 19));
            if (k < 3)       op = MUL;
            else if (k < 6)  op = DIV;
            else if (k == 6) op = HALT;
            else if (k < 14) op = LOAD;
            else             op = 5'($urandom_range(2, 11));
            apply_stimulus(($urandom_range(0, 39) == 0) || (ma.halted && $urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 3) != 0), op, 1'($urandom_range(0, 1)),
                           3'($urandom_range(0, 7)), 1'($urandom_range(0, 4) == 0),
                           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
